adc_sample_collector: RTL and testbench

Collects 12-bit ADC samples delivered by the SPI ADC receiver, one per multiplexer position, into a double-buffered channel table. It publishes a complete sweep to the frame-filling stage while the next sweep is being captured. The block sits between the SPI ADC receiver (`spiData`/`spiReady`) and the frame filler's analog-data read port, in the `clk80` domain.

---
 rtl/adc_sample_collector.sv | 158 +++++++++++++++
 tb/tb_adc_sample_collector.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_collector.sv
// Double-buffered channel table for one multiplexer sweep of SPI ADC samples.
// The write bank fills while the read bank is served to the frame filler.
module adc_sample_collector #(
    parameter int CHANNELS = 24,
    parameter int WIDTH    = 12,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  spiData,
    input  logic              spiReady,
    input  logic              cycleStart,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WIDTH-1:0]  rdData,
    output logic              tableReady,
    output logic              bankSel,
    output logic              overrun,
    output logic [7:0]        missCount
);

    localparam int IDX_W = $clog2(CHANNELS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS);
    localparam logic [ADDR_W:0]   CH_LIMIT = (ADDR_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   wr_idx_r, idx_base_s, idx_n, wr_slot_s;
    logic               bank_r, bank_n, wr_bank_s;
    logic               take_s, close_s, ovr_set_s;
    logic [WIDTH-1:0]   mem_r [2][CHANNELS];
    logic [CHANNELS-1:0] valid_r [2];
    logic [WIDTH-1:0]   rd_data_r, rd_word_s;
    logic               ready_r, overrun_r;
    logic [7:0]         miss_r;

    // Sweep sequencing: a close is resolved before a coincident sample, which then lands in slot 0.
    always_comb begin
        state_n    = state_r;
        idx_base_s = wr_idx_r;
        bank_n     = bank_r;
        take_s     = 1'b0;
        close_s    = 1'b0;
        ovr_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cycleStart) begin
                    idx_base_s = '0;
                    state_n    = ST_FILL;
                    take_s     = spiReady;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (cycleStart) begin
                    close_s    = 1'b1;
                    bank_n     = ~bank_r;
                    idx_base_s = '0;
                    state_n    = ST_FILL;
                    take_s     = spiReady;
                end else begin
                    take_s     = spiReady;
                end
            end
            ST_FULL: begin
                if (cycleStart) begin
                    close_s    = 1'b1;
                    bank_n     = ~bank_r;
                    idx_base_s = '0;
                    state_n    = ST_FILL;
                    take_s     = spiReady;
                end else begin
                    ovr_set_s  = spiReady;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        wr_slot_s = idx_base_s;
        wr_bank_s = ~bank_n;
        if (take_s) begin
            idx_n = idx_base_s + IDX_W'(1);
            if (idx_n == LAST_IDX) begin
                state_n = ST_FULL;
            end else begin
                state_n = ST_FILL;
            end
        end else begin
            idx_n = idx_base_s;
        end
    end

    // Read-port mux: out-of-range or never-written slots read as zero.
    always_comb begin
        rd_word_s = '0;
        if (({1'b0, rdAddr} < CH_LIMIT) && valid_r[bank_r][rdAddr]) begin
            rd_word_s = mem_r[bank_r][rdAddr];
        end else begin
            rd_word_s = '0;
        end
    end

    // Sample storage; contents are qualified by the valid masks, so no reset is needed.
    always_ff @(posedge clk) begin
        if (take_s) begin
            mem_r[wr_bank_s][wr_slot_s] <= spiData;
        end
    end

    // Control state, valid masks, status and registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wr_idx_r   <= '0;
            bank_r     <= 1'b0;
            valid_r[0] <= '0;
            valid_r[1] <= '0;
            rd_data_r  <= '0;
            ready_r    <= 1'b0;
            overrun_r  <= 1'b0;
            miss_r     <= 8'd0;
        end else begin
            state_r  <= state_n;
            wr_idx_r <= idx_n;
            bank_r   <= bank_n;
            ready_r  <= close_s;
            if (close_s) begin
                valid_r[bank_r] <= '0;
            end
            if (take_s) begin
                valid_r[wr_bank_s][wr_slot_s] <= 1'b1;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end
            if (close_s && (state_r == ST_FILL) && (miss_r != 8'hFF)) begin
                miss_r <= miss_r + 8'd1;
            end
            if (rdEn) begin
                rd_data_r <= rd_word_s;
            end
        end
    end

    assign rdData     = rd_data_r;
    assign tableReady = ready_r;
    assign bankSel    = bank_r;
    assign overrun    = overrun_r;
    assign missCount  = miss_r;

endmodule

// File: tb/tb_adc_sample_collector.sv
// Directed bench for adc_sample_collector: sweeps, short sweeps, overrun,
// coincident close/sample, close-cycle reads, saturation and mid-sweep reset.
module tb_adc_sample_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] spiData;
    logic        spiReady;
    logic        cycleStart;
    logic        rdEn;
    logic [4:0]  rdAddr;
    logic [11:0] rdData;
    logic        tableReady;
    logic        bankSel;
    logic        overrun;
    logic [7:0]  missCount;

    int n_cmp = 0;
    int n_bad = 0;

    adc_sample_collector #(.CHANNELS(24), .WIDTH(12), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .spiData(spiData), .spiReady(spiReady),
        .cycleStart(cycleStart), .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
        .tableReady(tableReady), .bankSel(bankSel), .overrun(overrun),
        .missCount(missCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cycleStart = 1'b1;
        tick();
        cycleStart = 1'b0;
    endtask

    task automatic send(input logic [11:0] d);
        spiData  = d;
        spiReady = 1'b1;
        tick();
        spiReady = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [11:0] q);
        rdEn   = 1'b1;
        rdAddr = a;
        tick();
        rdEn   = 1'b0;
        q      = rdData;
    endtask

    task automatic test_reset();
        reset = 1'b0; spiData = 12'd0; spiReady = 1'b0; cycleStart = 1'b0;
        rdEn = 1'b0; rdAddr = 5'd0;
        tick(); tick();
        n_cmp++;
        if ({rdData, tableReady, bankSel, overrun, missCount} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%h tr=%b bs=%b ov=%b mc=%0d, want all 0",
                     rdData, tableReady, bankSel, overrun, missCount);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_full_sweep();
        logic [11:0] q;
        logic [11:0] exp;
        send(12'h777);
        pulse_start();
        n_cmp++;
        if (tableReady !== 1'b0 || bankSel !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_start: tr=%b bs=%b, want 0 0", tableReady, bankSel);
        end
        for (int i = 0; i < 24; i++) send(12'h100 + 12'(i));
        pulse_start();
        n_cmp++;
        if (tableReady !== 1'b1 || bankSel !== 1'b1) begin
            n_bad++;
            $display("FAIL full_close: tr=%b bs=%b, want 1 1", tableReady, bankSel);
        end
        tick();
        n_cmp++;
        if (tableReady !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_pulse_width: tr=%b, want 0", tableReady);
        end
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), q);
            exp = (i < 24) ? 12'h100 + 12'(i) : 12'h000;
            n_cmp++;
            if (q !== exp) begin
                n_bad++;
                $display("FAIL full_read[%0d]: got %h want %h", i, q, exp);
            end
        end
        n_cmp++;
        if (missCount !== 8'd0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL full_status: mc=%0d ov=%b, want 0 0", missCount, overrun);
        end
    endtask

    task automatic test_short_sweep();
        logic [11:0] q;
        logic [11:0] exp;
        for (int i = 0; i < 10; i++) send(12'hA00 + 12'(i));
        pulse_start();
        n_cmp++;
        if (bankSel !== 1'b0 || missCount !== 8'd1) begin
            n_bad++;
            $display("FAIL short_close: bs=%b mc=%0d, want 0 1", bankSel, missCount);
        end
        for (int i = 0; i < 24; i++) begin
            rd(5'(i), q);
            exp = (i < 10) ? 12'hA00 + 12'(i) : 12'h000;
            n_cmp++;
            if (q !== exp) begin
                n_bad++;
                $display("FAIL short_read[%0d]: got %h want %h", i, q, exp);
            end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] q;
        logic [11:0] exp;
        for (int i = 0; i < 24; i++) send(12'hB00 + 12'(i));
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_early: got %b want 0", overrun);
        end
        send(12'hB18);
        send(12'hB19);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), q);
            exp = (i < 24) ? 12'hB00 + 12'(i) : 12'h000;
            n_cmp++;
            if (q !== exp) begin
                n_bad++;
                $display("FAIL overrun_read[%0d]: got %h want %h", i, q, exp);
            end
        end
        n_cmp++;
        if (missCount !== 8'd1) begin
            n_bad++;
            $display("FAIL overrun_miss: got %0d want 1", missCount);
        end
        pulse_start();
        rd(5'd0, q);
        n_cmp++;
        if (overrun !== 1'b1 || missCount !== 8'd2 || q !== 12'h000) begin
            n_bad++;
            $display("FAIL overrun_sticky: ov=%b mc=%0d rd0=%h, want 1 2 000", overrun, missCount, q);
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] q;
        for (int i = 0; i < 24; i++) send(12'hC00 + 12'(i));
        spiData = 12'h5A5; spiReady = 1'b1; cycleStart = 1'b1;
        tick();
        spiReady = 1'b0; cycleStart = 1'b0;
        n_cmp++;
        if (tableReady !== 1'b1 || missCount !== 8'd2) begin
            n_bad++;
            $display("FAIL sim_close: tr=%b mc=%0d, want 1 2", tableReady, missCount);
        end
        for (int i = 0; i < 24; i++) begin
            rd(5'(i), q);
            n_cmp++;
            if (q !== 12'hC00 + 12'(i)) begin
                n_bad++;
                $display("FAIL sim_read[%0d]: got %h want %h", i, q, 12'hC00 + 12'(i));
            end
        end
        pulse_start();
        rd(5'd0, q);
        n_cmp++;
        if (q !== 12'h5A5) begin
            n_bad++;
            $display("FAIL sim_slot0: got %h want 5a5", q);
        end
        rd(5'd1, q);
        n_cmp++;
        if (q !== 12'h000 || missCount !== 8'd3) begin
            n_bad++;
            $display("FAIL sim_slot1: rd1=%h mc=%0d, want 000 3", q, missCount);
        end
    endtask

    task automatic test_read_in_close();
        logic [11:0] q;
        send(12'hD00);
        cycleStart = 1'b1; rdEn = 1'b1; rdAddr = 5'd0;
        tick();
        cycleStart = 1'b0; rdEn = 1'b0;
        n_cmp++;
        if (rdData !== 12'h5A5) begin
            n_bad++;
            $display("FAIL close_cycle_read: got %h want 5a5", rdData);
        end
        rd(5'd0, q);
        n_cmp++;
        if (q !== 12'hD00 || missCount !== 8'd4) begin
            n_bad++;
            $display("FAIL post_close_read: rd=%h mc=%0d, want d00 4", q, missCount);
        end
        tick();
        n_cmp++;
        if (rdData !== 12'hD00) begin
            n_bad++;
            $display("FAIL read_hold: got %h want d00", rdData);
        end
    endtask

    task automatic test_saturate();
        int pulses;
        for (int i = 0; i < 246; i++) begin
            pulse_start();
            tick();
        end
        n_cmp++;
        if (missCount !== 8'd250) begin
            n_bad++;
            $display("FAIL miss_250: got %0d want 250", missCount);
        end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            pulse_start();
            if (tableReady === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (missCount !== 8'd255 || pulses != 50) begin
            n_bad++;
            $display("FAIL miss_saturate: mc=%0d pulses=%0d, want 255 50", missCount, pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] q;
        send(12'hF01);
        send(12'hF02);
        reset = 1'b0;
        #2;
        n_cmp++;
        if ({rdData, tableReady, bankSel, overrun, missCount} !== 23'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: rd=%h tr=%b bs=%b ov=%b mc=%0d, want all 0",
                     rdData, tableReady, bankSel, overrun, missCount);
        end
        tick();
        reset = 1'b1;
        tick();
        send(12'hE00);
        pulse_start();
        n_cmp++;
        if (tableReady !== 1'b0 || bankSel !== 1'b0 || missCount !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_reset_start: tr=%b bs=%b mc=%0d, want 0 0 0", tableReady, bankSel, missCount);
        end
        send(12'hE01);
        pulse_start();
        rd(5'd0, q);
        n_cmp++;
        if (q !== 12'hE01 || bankSel !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_slot0: rd=%h bs=%b, want e01 1", q, bankSel);
        end
        rd(5'd1, q);
        n_cmp++;
        if (q !== 12'h000 || missCount !== 8'd1) begin
            n_bad++;
            $display("FAIL mid_reset_slot1: rd=%h mc=%0d, want 000 1", q, missCount);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_short_sweep();
        test_overrun();
        test_simultaneous();
        test_read_in_close();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
